// File: rtl/conv_pkg.sv
// Shared constants for the conv_xpose transpose buffer: the activation width,
// the lane-slice width, the FSM encoding and an index-width helper.
package conv_pkg;

  localparam int BW          = 8;
  localparam int NUM_FILTERS = 8;
  localparam int VEC_BW      = NUM_FILTERS * BW;

  localparam logic [0:0] ST_FILL  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  // Counter width for a range of n entries; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_xpose_bank.sv
// One frame of storage: FRAME_LEN rows of NUM_FILTERS lanes, written one lane
// at a time and read a whole row at a time through a combinational mux.
module conv_xpose_bank #(
  parameter int FRAME_LEN   = 50,
  parameter int NUM_FILTERS = 8,
  parameter int BW          = 8
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          we,
  input  logic [conv_pkg::idx_w(FRAME_LEN)-1:0]         wrow,
  input  logic [conv_pkg::idx_w(NUM_FILTERS)-1:0]       wlane,
  input  logic [BW-1:0]                                 wdata,
  input  logic [conv_pkg::idx_w(FRAME_LEN)-1:0]         rrow,
  output logic [NUM_FILTERS*BW-1:0]                     rdata
);

  logic [NUM_FILTERS*BW-1:0] mem [FRAME_LEN];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: this array is built from plain flops, so it is cleared on reset;
      // a RAM macro could not be, and would need the clear done by the FSM.
      for (int r = 0; r < FRAME_LEN; r++) mem[r] <= '0;
    end else if (we) begin
      mem[wrow][wlane*BW +: BW] <= wdata;
    end
  end

  assign rdata = mem[rrow];

endmodule

// File: rtl/conv_xpose.sv
// Filter-major to position-major transpose between two conv1d layers.
// Define CONV_XPOSE_PINGPONG_EN for two banks so filling overlaps draining.
module conv_xpose #(
  parameter int FRAME_LEN   = 50,
  parameter int NUM_FILTERS = conv_pkg::NUM_FILTERS,
  parameter int BW          = conv_pkg::BW
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [BW-1:0]                 data_i,
  input  logic                          valid_i,
  input  logic                          last_i,
  output logic                          ready_o,
  output logic [NUM_FILTERS*BW-1:0]     data_o,
  output logic                          valid_o,
  output logic                          last_o,
  input  logic                          ready_i,
  output logic                          err_o
);

  import conv_pkg::*;

  localparam int VW = NUM_FILTERS * BW;
  localparam int RW = idx_w(FRAME_LEN);
  localparam int LW = idx_w(NUM_FILTERS);
  localparam logic [RW-1:0] ROW_LAST  = RW'(FRAME_LEN - 1);
  localparam logic [LW-1:0] LANE_LAST = LW'(NUM_FILTERS - 1);

`ifdef CONV_XPOSE_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  // Bank selects toggle per frame only when the second bank exists.
  localparam logic PINGPONG = (NB == 2);

  logic [0:0]    bank_st [2];
  logic          wsel, rsel;
  logic [RW-1:0] wp, rp;
  logic [LW-1:0] wf;
  logic          err;
  logic [VW-1:0] rdata [2];
  logic          accept, emit, final_elem, frame_end;

  assign ready_o    = !rst_i && (bank_st[wsel] == ST_FILL);
  assign valid_o    = !rst_i && (bank_st[rsel] == ST_DRAIN);
  assign last_o     = valid_o && (rp == ROW_LAST);
  assign data_o     = valid_o ? rdata[rsel] : '0;
  assign err_o      = err;

  assign accept     = valid_i && ready_o;
  assign emit       = valid_o && ready_i;
  assign final_elem = (wf == LANE_LAST) && (wp == ROW_LAST);
  assign frame_end  = accept && (final_elem || last_i);

  // NOTE: every register below is state, so only non-blocking assignments are
  // used here; blocking ones would let later statements see updated values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_st[0] <= ST_FILL;
      bank_st[1] <= ST_FILL;
      wsel       <= 1'b0;
      rsel       <= 1'b0;
      wp         <= '0;
      wf         <= '0;
      rp         <= '0;
      err        <= 1'b0;
    end else begin
      if (accept) begin
        if (frame_end) begin
          // An early or missing last_i still closes the frame; it is flagged.
          bank_st[wsel] <= ST_DRAIN;
          wsel          <= wsel ^ PINGPONG;
          wp            <= '0;
          wf            <= '0;
          if (final_elem != last_i) err <= 1'b1;
        end else if (wp == ROW_LAST) begin
          wp <= '0;
          wf <= wf + 1'b1;
        end else begin
          wp <= wp + 1'b1;
        end
      end
      // Fill and drain never target the same bank in one cycle.
      if (emit) begin
        if (last_o) begin
          bank_st[rsel] <= ST_FILL;
          rsel          <= rsel ^ PINGPONG;
          rp            <= '0;
        end else begin
          rp <= rp + 1'b1;
        end
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    if (b < NB) begin : g_on
      conv_xpose_bank #(
        .FRAME_LEN   (FRAME_LEN),
        .NUM_FILTERS (NUM_FILTERS),
        .BW          (BW)
      ) u_bank (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .we    (accept && (wsel == 1'(b))),
        .wrow  (wp),
        .wlane (wf),
        .wdata (data_i),
        .rrow  (rp),
        .rdata (rdata[b])
      );
    end else begin : g_off
      assign rdata[b] = '0;
    end
  end

endmodule

// File: tb/tb_conv_xpose.sv
// Self-checking bench for conv_xpose (FRAME_LEN=4, NUM_FILTERS=2): a frame
// model pushes expected columns on input accept; a monitor pops and compares.
module tb_conv_xpose;

  localparam int FL = 4;
  localparam int NF = 2;
`ifdef CONV_XPOSE_PINGPONG_EN
  localparam logic PP = 1'b1;
`else
  localparam logic PP = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] vec;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i, valid_i, last_i, ready_i;
  logic [7:0]  data_i;
  logic        ready_o, valid_o, last_o, err_o;
  logic [15:0] data_o;

  int n_vec = 0;
  int n_bad = 0;
  int n_cols = 0;
  int total_waits = 0;

  exp_t       q[$];
  logic [7:0] mmem [2][FL][NF];
  int         mp, mf;
  logic       mwsel;
  logic       stall_prev = 1'b0;
  logic [15:0] held_vec;
  logic       held_last;

  conv_xpose #(
    .FRAME_LEN   (FL),
    .NUM_FILTERS (NF),
    .BW          (8)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .last_i  (last_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .last_o  (last_o),
    .ready_i (ready_i),
    .err_o   (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: model the frame buffer on accepts, compare on output handshakes.
  always @(negedge clk) begin
    if (rst_i) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < FL; r++)
          for (int l = 0; l < NF; l++) mmem[b][r][l] = 8'h00;
      mp = 0; mf = 0; mwsel = 1'b0;
      q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 16'(valid_o), 16'd1);
        check("hold_data", data_o, held_vec);
        check("hold_last", 16'(last_o), 16'(held_last));
      end
      if (valid_o && ready_i) begin
        check("col_expected", 16'(q.size() != 0), 16'd1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          check("col_data", data_o, e.vec);
          check("col_last", 16'(last_o), 16'(e.last));
        end
        n_cols++;
      end
      stall_prev = valid_o && !ready_i;
      held_vec   = data_o;
      held_last  = last_o;
      if (valid_i && ready_o) begin
        logic fin;
        mmem[mwsel][mp][mf] = data_i;
        fin = (mf == NF-1) && (mp == FL-1);
        if (fin || last_i) begin
          for (int r = 0; r < FL; r++)
            q.push_back('{vec: {mmem[mwsel][r][1], mmem[mwsel][r][0]}, last: (r == FL-1)});
          mp = 0; mf = 0; mwsel = mwsel ^ PP;
        end else if (mp == FL-1) begin
          mp = 0; mf++;
        end else begin
          mp++;
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    int waits;
    valid_i = 1'b1; data_i = d; last_i = l;
    waits = 0;
    forever begin
      @(negedge clk);
      if (ready_o) break;
      waits++;
      if (waits > 200) begin
        check("accept_timeout", 16'(ready_o), 16'd1);
        break;
      end
    end
    total_waits += waits;
    @(posedge clk); #1;
  endtask

  // Element k is (f = k / FL, p = k % FL) with value base + f*16 + p.
  task automatic send_frame(input logic [7:0] base, input int last_at, input int count, input int neg_at);
    for (int k = 0; k < count; k++) begin
      logic [7:0] d;
      d = base + 8'((k / FL) * 16 + (k % FL));
      if (k == neg_at) d = 8'h80;
      send(d, k == last_at);
    end
  endtask

  task automatic idle();
    valid_i = 1'b0; last_i = 1'b0; data_i = 8'h00;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !valid_o) done = 1'b1;
    end
    if (!done) check("drain_timeout", 16'(valid_o), 16'd0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
  endtask

  initial begin
    logic [3:0] bp_pat;
    bp_pat = 4'b1001;
    rst_i = 1'b1; valid_i = 1'b0; last_i = 1'b0; data_i = 8'h00; ready_i = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 16'(ready_o), 16'd0);
    check("rst_valid", 16'(valid_o), 16'd0);
    check("rst_last", 16'(last_o), 16'd0);
    check("rst_err", 16'(err_o), 16'd0);
    check("rst_data", data_o, 16'h0000);
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 16'(ready_o), 16'd1);
    @(posedge clk); #1;

    // Basic transpose
    send_frame(8'h00, 7, 8, -1);
    idle();
    @(negedge clk);
    check("basic_valid_latency", 16'(valid_o), 16'd1);
    check("basic_ready_in_drain", 16'(ready_o), 16'(PP));
    check("basic_first_col", data_o, 16'h1000);
    @(posedge clk); #1;
    wait_drain();
    check("basic_err", 16'(err_o), 16'd0);
    check("basic_cols", 16'(n_cols), 16'd4);

    // Backpressure: ready_i cycles 1,0,0,1 through the drain
    send_frame(8'h05, 7, 8, -1);
    idle();
    for (int i = 0; i < 60 && !(q.size() == 0 && !valid_o); i++) begin
      ready_i = bp_pat[i % 4];
      @(negedge clk);
      if (valid_o) check("bp_ready_in_drain", 16'(ready_o), 16'(PP));
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    check("bp_cols", 16'(n_cols), 16'd8);

    // Early last on the 5th element
    send_frame(8'h20, 4, 5, -1);
    idle();
    @(negedge clk);
    check("early_err", 16'(err_o), 16'd1);
    check("early_valid", 16'(valid_o), 16'd1);
    @(posedge clk); #1;
    wait_drain();
    send_frame(8'h30, 7, 8, -1);
    idle();
    wait_drain();
    check("err_sticky", 16'(err_o), 16'd1);

    // Mid-frame reset, then a frame carrying -128 at (1,2)
    send_frame(8'h60, -1, 3, -1);
    idle();
    pulse_reset();
    @(negedge clk);
    check("midrst_valid", 16'(valid_o), 16'd0);
    check("midrst_data", data_o, 16'h0000);
    check("midrst_err", 16'(err_o), 16'd0);
    check("midrst_ready", 16'(ready_o), 16'd1);
    @(posedge clk); #1;
    send_frame(8'h00, 7, 8, 6);
    idle();
    wait_drain();
    check("neg_cols", 16'(n_cols), 16'd20);

    // Back-to-back frames with valid_i held high
    total_waits = 0;
    send_frame(8'h00, 7, 8, -1);
    send_frame(8'h40, 7, 8, -1);
    idle();
`ifdef CONV_XPOSE_PINGPONG_EN
    check("b2b_no_stall", 16'(total_waits), 16'd0);
`endif
    wait_drain();
    check("b2b_cols", 16'(n_cols), 16'd28);
    check("b2b_err", 16'(err_o), 16'd0);

    // Missing last_i on the final element
    send_frame(8'h50, -1, 8, -1);
    idle();
    @(negedge clk);
    check("nolast_err", 16'(err_o), 16'd1);
    check("nolast_valid", 16'(valid_o), 16'd1);
    @(posedge clk); #1;
    wait_drain();
    check("total_cols", 16'(n_cols), 16'd32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
